// File: rtl/arm_pkg.sv
// Shared ARM core constants: condition codes, NZCV bit positions and FlagW halves.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator over the architectural NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      // NV is unsupported: treat as a squash
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag registers, condition gating of decoder strobes.
// Optional squash counter enabled by defining COND_STATS_EN.
module cond_logic
  import arm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
`ifdef COND_STATS_EN
  output logic [CNT_W-1:0] SquashCnt,
`endif
  output logic             CondEx
);

  logic [3:0] flags_q, flags_d;
  logic [1:0] flag_we;

  // Condition is judged on the pre-update flags, never on ALUFlags
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (CondEx)
  );

  assign PCSrc    = PCS  & CondEx;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;
  assign flag_we  = FlagW & {2{CondEx}};
  assign Flags    = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (flag_we[FW_NZ]) flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
    if (flag_we[FW_CV]) flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

`ifdef COND_STATS_EN
  logic             squash;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign squash = ~CondEx & (PCS | RegW | MemW | (|FlagW));

  always_comb begin
    cnt_d = cnt_q;
    if (squash && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign SquashCnt = cnt_q;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic; stats checks compile only with COND_STATS_EN.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
`ifdef COND_STATS_EN
  logic [15:0] SquashCnt;
  logic [1:0]  SquashCnt2;
  logic        PCSrc2, RegWrite2, MemWrite2, CondEx2;
  logic [3:0]  Flags2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cond_logic #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags),
`ifdef COND_STATS_EN
    .SquashCnt(SquashCnt),
`endif
    .CondEx(CondEx)
  );

`ifdef COND_STATS_EN
  cond_logic #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .PCSrc(PCSrc2), .RegWrite(RegWrite2),
    .MemWrite(MemWrite2), .Flags(Flags2), .SquashCnt(SquashCnt2), .CondEx(CondEx2)
  );
`endif

  task automatic idle();
    Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
  endtask

  // Stimulus helper: write all four flags through an AL flag-setting instruction
  task automatic load_flags(input logic [3:0] v);
    @(negedge clk);
    idle();
    FlagW = 2'b11; ALUFlags = v;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    Cond = 4'b0000;
    #1;
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
    checks++;
    if (CondEx !== 1'b0) begin failures++; $display("FAIL reset_condex_eq got=%b exp=0", CondEx); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_gating();
    @(negedge clk);
    idle();
    Cond = 4'b1110; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
    #1;
    checks++;
    if ({PCSrc, RegWrite, MemWrite} !== 3'b111) begin failures++; $display("FAIL gate_al got=%b exp=111", {PCSrc, RegWrite, MemWrite}); end
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL gate_al_flags got=%b exp=0000", Flags); end
    Cond = 4'b0000;
    #1;
    checks++;
    if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin failures++; $display("FAIL gate_eq got=%b exp=000", {PCSrc, RegWrite, MemWrite}); end
  endtask

  task automatic test_flag_set();
    load_flags(4'b0100);
    checks++;
    if (Flags !== 4'b0100) begin failures++; $display("FAIL flagset_flags got=%b exp=0100", Flags); end
    @(negedge clk);
    Cond = 4'b0000; RegW = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b1) begin failures++; $display("FAIL flagset_eq got=%b exp=1", RegWrite); end
    Cond = 4'b0001;
    #1;
    checks++;
    if (RegWrite !== 1'b0) begin failures++; $display("FAIL flagset_ne got=%b exp=0", RegWrite); end
  endtask

  task automatic test_partial();
    load_flags(4'b1111);
    @(negedge clk);
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b0011) begin failures++; $display("FAIL partial_nz got=%b exp=0011", Flags); end
    @(negedge clk);
    FlagW = 2'b01; ALUFlags = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL partial_cv got=%b exp=0000", Flags); end
  endtask

  task automatic test_squash_flags();
    load_flags(4'b0000);
    @(negedge clk);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
    #1;
    checks++;
    if (CondEx !== 1'b0) begin failures++; $display("FAIL squash_condex got=%b exp=0", CondEx); end
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL squash_flags got=%b exp=0000", Flags); end
  endtask

  task automatic test_conds();
    // {flags, cond, expected CondEx}
    logic [8:0] vec [14];
    vec = '{
      {4'b1001, 4'b1010, 1'b1}, {4'b1001, 4'b1011, 1'b0}, {4'b1001, 4'b1100, 1'b1},
      {4'b0110, 4'b1000, 1'b0}, {4'b0110, 4'b1001, 1'b1},
      {4'b1000, 4'b1011, 1'b1}, {4'b1000, 4'b1101, 1'b1}, {4'b1000, 4'b1111, 1'b0},
      {4'b1000, 4'b0100, 1'b1}, {4'b1000, 4'b0101, 1'b0}, {4'b0010, 4'b0010, 1'b1},
      {4'b0010, 4'b0011, 1'b0}, {4'b0001, 4'b0110, 1'b1}, {4'b1010, 4'b1000, 1'b1}
    };
    for (int i = 0; i < 14; i++) begin
      load_flags(vec[i][8:5]);
      Cond = vec[i][4:1];
      #1;
      checks++;
      if (CondEx !== vec[i][0])
        begin failures++; $display("FAIL cond_%0d flags=%b cond=%b got=%b exp=%b", i, vec[i][8:5], vec[i][4:1], CondEx, vec[i][0]); end
    end
  endtask

  task automatic test_xsafe();
    load_flags(4'b0101);
    @(negedge clk);
    idle();
    ALUFlags = 4'bxxxx;
    @(posedge clk); #1;
    checks++;
    if ({PCSrc, RegWrite, MemWrite, Flags} !== 7'b000_0101)
      begin failures++; $display("FAIL xsafe got=%b exp=0000101", {PCSrc, RegWrite, MemWrite, Flags}); end
    idle();
  endtask

  task automatic test_back_to_back();
    load_flags(4'b0000);
    @(negedge clk);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    #1;
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL b2b_old got=%b exp=0000", Flags); end
    @(negedge clk);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0000; RegW = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b1) begin failures++; $display("FAIL b2b_consumer got=%b exp=1", RegWrite); end
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL b2b_update got=%b exp=0000", Flags); end
    checks++;
    if (RegWrite !== 1'b0) begin failures++; $display("FAIL b2b_next got=%b exp=0", RegWrite); end
    idle();
  endtask

  task automatic test_reset_override();
    load_flags(4'b1010);
    @(negedge clk);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL async_reset got=%b exp=0000", Flags); end
    @(posedge clk); #1;
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL reset_override got=%b exp=0000", Flags); end
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

`ifdef COND_STATS_EN
  task automatic test_stats();
    do_reset();
    load_flags(4'b0000);
    @(negedge clk);
    Cond = 4'b0000; RegW = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    Cond = 4'b1110;
    @(posedge clk); #1;
    checks++;
    if (SquashCnt !== 16'd3) begin failures++; $display("FAIL stats_count got=%0d exp=3", SquashCnt); end
    @(negedge clk);
    Cond = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (SquashCnt !== 16'd5) begin failures++; $display("FAIL stats_count5 got=%0d exp=5", SquashCnt); end
    checks++;
    if (SquashCnt2 !== 2'd3) begin failures++; $display("FAIL stats_saturate got=%0d exp=3", SquashCnt2); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (SquashCnt !== 16'd0) begin failures++; $display("FAIL stats_reset got=%0d exp=0", SquashCnt); end
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_gating();
    test_flag_set();
    test_partial();
    test_squash_flags();
    test_conds();
    test_xsafe();
    test_back_to_back();
    test_reset_override();
`ifdef COND_STATS_EN
    test_stats();
`else
    do_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage for the single-cycle ARM core. Sits directly downstream of the instruction decoder.
- Consumes the decoder's raw write/branch requests (PCS, RegW, MemW, FlagW) together with the instruction condition field Instr[31:28] and the ALU flags.
- Holds the architectural NZCV flag registers and evaluates the condition against them. Gates the requests into the final PCSrc/RegWrite/MemWrite strobes used by the datapath.

Parameters:
- CNT_W, 16, width of the squash counter (used only when COND_STATS_EN is defined).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Cond  input  4  instruction condition field Instr[31:28].
- ALUFlags  input  4  current ALU result flags, ordered {N,Z,C,V}.
- FlagW  input  2  from decoder. [1] requests an N,Z update; [0] requests a C,V update.
- PCS  input  1  from decoder: PC-write request (branch or write to R15).
- RegW  input  1  from decoder: register-file write request.
- MemW  input  1  from decoder: data-memory write request.
- PCSrc  output  1  gated PC-source select.
- RegWrite  output  1  gated register write enable.
- MemWrite  output  1  gated memory write enable.
- Flags  output  4  registered architectural flags {N,Z,C,V}.
- CondEx  output  1  condition-passed indicator for the current instruction.
- SquashCnt  output  CNT_W  count of squashed instructions (present only with COND_STATS_EN).

Behaviour:
- Reset, asynchronous and active-high. Flags=4'b0000 and SquashCnt=0 immediately. Combinational outputs follow from Flags=0: e.g. Cond=EQ gives CondEx=0.
- Condition evaluation is combinational on the registered Flags (the pre-update value), never on ALUFlags. Zero latency, same cycle as decode. Codes:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: CondEx=0. This code is unsupported and is treated as a squash.
- Gated strobes: PCSrc=PCS&CondEx, RegWrite=RegW&CondEx, MemWrite=MemW&CondEx.
- Flag write enables: FlagWrite[1]=FlagW[1]&CondEx and FlagWrite[0]=FlagW[0]&CondEx.
- On the rising edge:
  - If FlagWrite[1]: N,Z <= ALUFlags[3:2].
  - If FlagWrite[0]: C,V <= ALUFlags[1:0].
  - Halves are independent. FlagW=2'b10 updates N,Z only and holds C,V.
- A failed condition never modifies flags, even when FlagW is nonzero.
- A flag-setting instruction sees the old flags for its own condition. The next instruction sees the new flags, so there is one cycle from producer to consumer.
- X-safety: when the decoder drives X on unused ALU controls, FlagW/PCS/RegW/MemW remain defined. Outputs must not depend on undefined inputs when all requests are 0.
- Reset asserted mid-operation overrides any pending flag write in that cycle.

Optional Feature:
- Macro: COND_STATS_EN.
- Defined: a CNT_W-bit register SquashCnt increments on each clock edge where CondEx=0 and (PCS|RegW|MemW|FlagW!=0), i.e. an instruction with effect was squashed. It saturates at all-ones (no wrap) and resets to 0. The SquashCnt port exists.
- Undefined: no counter and no SquashCnt port. Core behaviour is identical.

Decomposition:
- Shared package `arm_pkg`:
  - cond-code localparams (COND_EQ..COND_AL, COND_NV=4'b1111)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
  - FlagW bit indices (FW_NZ=1, FW_CV=0)
- One natural sub-module: `cond_check`. It is purely combinational, with inputs Cond and Flags and output CondEx.
- Flag registers, gating and the optional counter stay in cond_logic.

Test Plan:
- Reset then Cond=1110, RegW=1, MemW=1, PCS=1 -> RegWrite=MemWrite=PCSrc=1 and Flags=0000. Repeat with Cond=0000 -> all gated outputs 0.
- Flag-setting pass: Cond=AL, FlagW=11, ALUFlags=0100.
  - After the edge, Flags=0100.
  - Next cycle Cond=EQ, RegW=1 -> RegWrite=1.
  - Cond=NE -> RegWrite=0.
- Partial update: Flags=1111, then FlagW=10, ALUFlags=0000, Cond=AL -> Flags=0011. Then FlagW=01, ALUFlags=0000 -> Flags=0000.
- Squashed flag write: Flags=0000, Cond=EQ, FlagW=11, ALUFlags=1111 -> CondEx=0 and Flags stays 0000 after the edge.
- Signed and unsigned conditions:
  - Flags=1001 -> GE=1, LT=0, GT=1.
  - Flags=0110 -> HI=0, LS=1.
  - Flags=1000 -> LT=1, LE=1.
  - Cond=1111 -> CondEx=0.
- COND_STATS_EN: 3 squashed RegW=1 instructions and 1 passing instruction -> SquashCnt=3. Mid-test async reset -> SquashCnt=0 immediately. With CNT_W=2, 5 squashes -> SquashCnt=3 (saturated).
